// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/execute sequencer for the 8-bit ALU datapath.
// Fetches 16-bit words from a synchronous program ROM, keeps a 4 x 8-bit
// register file, presents operands/opcode to the ALU and writes results back.
// Ports:
//   clk, rst (async, active-low), start
//   imem_addr / imem_data              : program ROM interface
//   alu_a, alu_b, alu_opcode           : operands and operation to the ALU
//   alu_result, alu_carry              : combinational ALU response
//   wb_valid, wb_data                  : write-back pulse and value
//   carry_flag, busy, halted           : status
module alu_sequencer #(
   parameter int unsigned     PC_W         = 8,
   parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic [PC_W-1:0] imem_addr,
   input  logic [15:0]     imem_data,
   output logic [7:0]      alu_a,
   output logic [7:0]      alu_b,
   output logic [2:0]      alu_opcode,
   input  logic [7:0]      alu_result,
   input  logic            alu_carry,
   output logic            wb_valid,
   output logic [7:0]      wb_data,
   output logic            carry_flag,
   output logic            busy,
   output logic            halted
);

   localparam int unsigned DW   = 8;
   localparam int unsigned NREG = 4;
   localparam int unsigned RW   = 2;
   localparam int unsigned OPW  = 3;

   localparam logic [OPW-1:0] OP_LDI  = OPW'(0);
   localparam logic [OPW-1:0] OP_JMP  = OPW'(1);
   localparam logic [OPW-1:0] OP_JC   = OPW'(2);
   localparam logic [OPW-1:0] OP_HALT = OPW'(3);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_FWAIT = 3'd2,
      S_EXEC  = 3'd3,
      S_WB    = 3'd4,
      S_HALT  = 3'd5
   } state_e;

   state_e state_q, state_d;

   logic [PC_W-1:0]           pc_q, pc_d;
   logic [PC_W-1:0]           imem_addr_q, imem_addr_d;
   logic [OPW-1:0]            ir_op_q, ir_op_d;
   logic                      ir_mode_q, ir_mode_d;
   logic [RW-1:0]             ir_rd_q, ir_rd_d;
   logic [DW-1:0]             ir_imm_q, ir_imm_d;
   logic [NREG-1:0][DW-1:0]   rf_q, rf_d;
   logic [DW-1:0]             alu_a_q, alu_a_d;
   logic [DW-1:0]             alu_b_q, alu_b_d;
   logic [OPW-1:0]            alu_op_q, alu_op_d;
   logic                      wb_valid_q, wb_valid_d;
   logic [DW-1:0]             wb_data_q, wb_data_d;
   logic                      carry_q, carry_d;
   logic                      busy_q, busy_d;
   logic                      halted_q, halted_d;

   // Word arriving from ROM in FWAIT is a HALT; it skips EXEC so halted
   // rises in the instruction's third cycle.
   logic fw_is_halt;
   assign fw_is_halt = imem_data[12] && (imem_data[15:13] == OP_HALT);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_FETCH;
         S_FETCH: state_d = S_FWAIT;
         S_FWAIT: state_d = fw_is_halt ? S_HALT : S_EXEC;
         S_EXEC:  state_d = (!ir_mode_q || ir_op_q == OP_LDI) ? S_WB : S_FETCH;
         S_WB:    state_d = S_FETCH;
         S_HALT:  if (start) state_d = S_FETCH;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and registered outputs
   always_comb begin
      pc_d        = pc_q;
      imem_addr_d = imem_addr_q;
      ir_op_d     = ir_op_q;
      ir_mode_d   = ir_mode_q;
      ir_rd_d     = ir_rd_q;
      ir_imm_d    = ir_imm_q;
      rf_d        = rf_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      wb_valid_d  = 1'b0;
      wb_data_d   = wb_data_q;
      carry_d     = carry_q;

      case (state_q)
         S_IDLE, S_HALT: begin
            if (start) pc_d = RESET_VECTOR;
         end
         S_FWAIT: begin
            ir_op_d   = imem_data[15:13];
            ir_mode_d = imem_data[12];
            ir_rd_d   = imem_data[11:10];
            ir_imm_d  = imem_data[7:0];
            pc_d      = pc_q + PC_W'(1);
            if (!imem_data[12]) begin
               alu_a_d  = rf_q[imem_data[11:10]];
               alu_b_d  = rf_q[imem_data[9:8]];
               alu_op_d = imem_data[15:13];
            end
         end
         // Results commit on the EXEC->WB edge so they are visible during WB.
         S_EXEC: begin
            if (!ir_mode_q) begin
               rf_d[ir_rd_q] = alu_result;
               wb_valid_d    = 1'b1;
               wb_data_d     = alu_result;
               carry_d       = alu_carry;
            end else begin
               case (ir_op_q)
                  OP_LDI: begin
                     rf_d[ir_rd_q] = ir_imm_q;
                     wb_valid_d    = 1'b1;
                     wb_data_d     = ir_imm_q;
                  end
                  OP_JMP:  pc_d = ir_imm_q[PC_W-1:0];
                  OP_JC:   if (carry_q) pc_d = ir_imm_q[PC_W-1:0];
                  default: ;
               endcase
            end
         end
         default: ;
      endcase

      // ROM address is presented for the whole FETCH cycle.
      if (state_d == S_FETCH) imem_addr_d = pc_d;

      busy_d   = (state_d == S_FETCH) || (state_d == S_FWAIT) ||
                 (state_d == S_EXEC)  || (state_d == S_WB);
      halted_d = (state_d == S_HALT);
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q        <= RESET_VECTOR;
         imem_addr_q <= RESET_VECTOR;
         ir_op_q     <= '0;
         ir_mode_q   <= 1'b0;
         ir_rd_q     <= '0;
         ir_imm_q    <= '0;
         rf_q        <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         wb_valid_q  <= 1'b0;
         wb_data_q   <= '0;
         carry_q     <= 1'b0;
         busy_q      <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         imem_addr_q <= imem_addr_d;
         ir_op_q     <= ir_op_d;
         ir_mode_q   <= ir_mode_d;
         ir_rd_q     <= ir_rd_d;
         ir_imm_q    <= ir_imm_d;
         rf_q        <= rf_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         wb_valid_q  <= wb_valid_d;
         wb_data_q   <= wb_data_d;
         carry_q     <= carry_d;
         busy_q      <= busy_d;
         halted_q    <= halted_d;
      end
   end

   assign imem_addr  = imem_addr_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_opcode = alu_op_q;
   assign wb_valid   = wb_valid_q;
   assign wb_data    = wb_data_q;
   assign carry_flag = carry_q;
   assign busy       = busy_q;
   assign halted     = halted_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: self-checking bench for alu_sequencer.
// An instruction-level reference model expands each program into the
// per-cycle output trace the sequencer must produce; every cycle of a run is
// compared against it. Directed programs pin the model with literal values.
module tb_alu_sequencer;

   localparam int unsigned PC_W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, start;
   logic [PC_W-1:0] imem_addr;
   logic [15:0]     imem_data;
   logic [7:0]      alu_a, alu_b, alu_result, wb_data;
   logic [2:0]      alu_opcode;
   logic            alu_carry, wb_valid, carry_flag, busy, halted;

   // second instance with a non-zero reset vector
   logic            start2;
   logic [PC_W-1:0] imem_addr2;
   logic [15:0]     imem_data2;
   logic [7:0]      alu_a2, alu_b2, wb_data2;
   logic [7:0]      alu_result2;
   logic [2:0]      alu_op2;
   logic            alu_carry2, wb_valid2, carry_flag2, busy2, halted2;

   logic [15:0] rom [256];

   int n_checks = 0;
   int n_fail   = 0;

   alu_sequencer #(.PC_W(PC_W), .RESET_VECTOR(8'h00)) u_dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_result(alu_result), .alu_carry(alu_carry),
      .wb_valid(wb_valid), .wb_data(wb_data), .carry_flag(carry_flag),
      .busy(busy), .halted(halted)
   );

   alu_sequencer #(.PC_W(PC_W), .RESET_VECTOR(8'hFF)) u_rv (
      .clk(clk), .rst(rst), .start(start2),
      .imem_addr(imem_addr2), .imem_data(imem_data2),
      .alu_a(alu_a2), .alu_b(alu_b2), .alu_opcode(alu_op2),
      .alu_result(alu_result2), .alu_carry(alu_carry2),
      .wb_valid(wb_valid2), .wb_data(wb_data2), .carry_flag(carry_flag2),
      .busy(busy2), .halted(halted2)
   );

   // bench ALU: {carry, result}
   function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
      case (op)
         3'd0:    return {1'b0, a} + {1'b0, b};
         3'd1:    return {1'b0, a} - {1'b0, b};
         3'd2:    return {1'b0, a & b};
         3'd3:    return {1'b0, a | b};
         3'd4:    return {1'b0, a ^ b};
         3'd5:    return {a, 1'b0};
         3'd6:    return {a[0], 1'b0, a[7:1]};
         default: return {1'b0, ~a};
      endcase
   endfunction

   assign {alu_carry, alu_result} = alu_f(alu_a, alu_b, alu_opcode);
   assign alu_result2 = 8'h00;
   assign alu_carry2  = 1'b0;

   always @(posedge clk) imem_data  <= rom[imem_addr];
   always @(posedge clk) imem_data2 <= (imem_addr2 == 8'hFF) ? 16'h9000 : 16'h7000;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
      logic       wbv;
      logic [7:0] wbd;
      logic       cf;
      logic       busy;
      logic       halted;
   } exp_t;

   exp_t       tr [$];
   logic [7:0] m_r [4];
   logic       m_cf;
   logic [7:0] m_a, m_b, m_wbd, m_addr;
   logic [2:0] m_op;

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
      m_cf = 1'b0; m_a = 8'h00; m_b = 8'h00; m_op = 3'd0;
      m_wbd = 8'h00; m_addr = 8'h00;
   endfunction

   function automatic void push_cycle(input logic bsy, input logic hlt, input logic wbv);
      exp_t e;
      e.addr = m_addr; e.a = m_a; e.b = m_b; e.op = m_op; e.wbv = wbv;
      e.wbd = m_wbd; e.cf = m_cf; e.busy = bsy; e.halted = hlt;
      tr.push_back(e);
   endfunction

   // Executes the ROM program from address 0, one instruction at a time.
   function automatic void build_trace();
      logic [7:0]  pc, pcn, imm;
      logic [15:0] ins;
      logic [2:0]  op;
      logic        mode;
      logic [1:0]  rd, rs;
      logic [8:0]  r;
      tr.delete();
      pc = 8'h00;
      for (int n = 0; n < 300; n++) begin
         ins = rom[pc];
         op = ins[15:13]; mode = ins[12]; rd = ins[11:10]; rs = ins[9:8]; imm = ins[7:0];
         m_addr = pc;
         push_cycle(1'b1, 1'b0, 1'b0);
         push_cycle(1'b1, 1'b0, 1'b0);
         pcn = pc + 8'd1;
         if (mode && op == 3'd3) begin
            push_cycle(1'b0, 1'b1, 1'b0);
            push_cycle(1'b0, 1'b1, 1'b0);
            return;
         end
         if (!mode) begin
            m_a = m_r[rd]; m_b = m_r[rs]; m_op = op;
            push_cycle(1'b1, 1'b0, 1'b0);
            r = alu_f(m_a, m_b, op);
            m_r[rd] = r[7:0]; m_cf = r[8]; m_wbd = r[7:0];
            push_cycle(1'b1, 1'b0, 1'b1);
         end else if (op == 3'd0) begin
            push_cycle(1'b1, 1'b0, 1'b0);
            m_r[rd] = imm; m_wbd = imm;
            push_cycle(1'b1, 1'b0, 1'b1);
         end else begin
            if (op == 3'd1 || (op == 3'd2 && m_cf)) pcn = imm;
            push_cycle(1'b1, 1'b0, 1'b0);
         end
         pc = pcn;
      end
      n_checks++; n_fail++;
      $display("FAIL model_halt: program did not reach HALT within 300 instructions");
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   logic [7:0] o_addr [512];
   logic [7:0] o_a    [512];
   logic [7:0] o_b    [512];
   logic [7:0] o_wbd  [512];
   logic [2:0] o_op   [512];
   logic       o_wbv  [512];
   logic       o_cf   [512];
   logic       o_halt [512];

   // Called at posedge+1 with the DUT in IDLE or HALT.
   task automatic run_prog(input bit noise);
      exp_t e;
      build_trace();
      start = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < tr.size() && i < 512; i++) begin
         e = tr[i];
         start = (noise && e.busy) ? ($urandom_range(0, 3) == 0) : 1'b0;
         @(negedge clk);
         chk($sformatf("c%0d.addr", i),   imem_addr,  e.addr);
         chk($sformatf("c%0d.alu_a", i),  alu_a,      e.a);
         chk($sformatf("c%0d.alu_b", i),  alu_b,      e.b);
         chk($sformatf("c%0d.op", i),     alu_opcode, e.op);
         chk($sformatf("c%0d.wbv", i),    wb_valid,   e.wbv);
         chk($sformatf("c%0d.wbd", i),    wb_data,    e.wbd);
         chk($sformatf("c%0d.cf", i),     carry_flag, e.cf);
         chk($sformatf("c%0d.busy", i),   busy,       e.busy);
         chk($sformatf("c%0d.halted", i), halted,     e.halted);
         o_addr[i] = imem_addr; o_a[i] = alu_a; o_b[i] = alu_b; o_op[i] = alu_opcode;
         o_wbv[i] = wb_valid; o_wbd[i] = wb_data; o_cf[i] = carry_flag; o_halt[i] = halted;
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   task automatic clear_rom();
      for (int a = 0; a < 256; a++) rom[a] = 16'h7000;
   endtask

   // Random program of len words; jumps only go forward so it always halts.
   task automatic gen_prog();
      int len;
      len = $urandom_range(3, 20);
      clear_rom();
      for (int a = 0; a < len; a++) begin
         logic [2:0] op;
         logic [1:0] rd, rs;
         logic [7:0] imm, tgt;
         int k;
         op  = 3'($urandom); rd = 2'($urandom); rs = 2'($urandom);
         imm = 8'($urandom);
         tgt = 8'($urandom_range(a + 1, len));
         k   = $urandom_range(0, 5);
         case (k)
            0, 1:    rom[a] = {op, 1'b0, rd, rs, imm};
            2:       rom[a] = {3'd0, 1'b1, rd, rs, imm};
            3:       rom[a] = {3'd1, 1'b1, rd, rs, tgt};
            4:       rom[a] = {3'd2, 1'b1, rd, rs, tgt};
            default: rom[a] = {3'($urandom_range(4, 7)), 1'b1, rd, rs, imm};
         endcase
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, ".addr"},   imem_addr,  8'h00);
      chk({nm, ".alu_a"},  alu_a,      8'h00);
      chk({nm, ".alu_b"},  alu_b,      8'h00);
      chk({nm, ".op"},     alu_opcode, 3'd0);
      chk({nm, ".wbv"},    wb_valid,   1'b0);
      chk({nm, ".wbd"},    wb_data,    8'h00);
      chk({nm, ".cf"},     carry_flag, 1'b0);
      chk({nm, ".busy"},   busy,       1'b0);
      chk({nm, ".halted"}, halted,     1'b0);
   endtask

   logic [7:0] r2_addr [8];
   logic       r2_halt [8];
   logic       r2_busy [8];
   int         npulse;

   initial begin
      rst = 1'b0; start = 1'b0; start2 = 1'b0;
      clear_rom();
      model_reset();

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      chk("reset.rv_addr", imem_addr2, 8'hFF);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;

      // T1: LDI R0,5; LDI R1,3; ADD R0,R1; HALT
      rom[0] = 16'h1005; rom[1] = 16'h1503; rom[2] = 16'h0100; rom[3] = 16'h7000;
      run_prog(1'b0);
      chk("t1.wb1_v", o_wbv[3], 1);   chk("t1.wb1_d", o_wbd[3], 8'h05);
      chk("t1.wb2_v", o_wbv[7], 1);   chk("t1.wb2_d", o_wbd[7], 8'h03);
      chk("t1.wb3_v", o_wbv[11], 1);  chk("t1.wb3_d", o_wbd[11], 8'h08);
      chk("t1.exec_a", o_a[10], 8'h05); chk("t1.exec_b", o_b[10], 8'h03);
      chk("t1.exec_op", o_op[10], 0);
      chk("t1.halt_c14", o_halt[13], 0); chk("t1.halt_c15", o_halt[14], 1);
      chk("t1.carry", o_cf[14], 0);
      npulse = 0;
      for (int i = 0; i < 16; i++) npulse += int'(o_wbv[i]);
      chk("t1.npulses", npulse, 3);

      // T2a: 0xF0+0x20 sets carry; JC taken
      clear_rom();
      rom[0] = 16'h10F0; rom[1] = 16'h1420; rom[2] = 16'h0100; rom[3] = 16'h5040;
      run_prog(1'b1);
      chk("t2a.wbd", o_wbd[11], 8'h10); chk("t2a.cf", o_cf[12], 1);
      chk("t2a.jc_addr", o_addr[15], 8'h40);

      // T2b: 0x10+0x20 clears carry; JC falls through
      clear_rom();
      rom[0] = 16'h1010; rom[1] = 16'h1420; rom[2] = 16'h0100; rom[3] = 16'h5040;
      run_prog(1'b1);
      chk("t2b.cf", o_cf[12], 0); chk("t2b.jc_addr", o_addr[15], 8'h04);

      // T3: JMP 0x22
      clear_rom();
      rom[0] = 16'h3022;
      run_prog(1'b1);
      chk("t3.fetch_addr", o_addr[0], 8'h00); chk("t3.jmp_addr", o_addr[3], 8'h22);

      // T3: RESET_VECTOR=0xFF with NOP there wraps to 0x00
      start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         r2_addr[i] = imem_addr2; r2_halt[i] = halted2; r2_busy[i] = busy2;
         @(posedge clk); #1;
      end
      chk("t3rv.addr_c1", r2_addr[0], 8'hFF);
      chk("t3rv.addr_c4", r2_addr[3], 8'h00);
      chk("t3rv.halted_c6", r2_halt[5], 1);
      chk("t3rv.busy_c6", r2_busy[5], 0);
      chk("t3rv.quiet", {alu_a2, alu_b2, alu_op2, wb_valid2, wb_data2, carry_flag2}, 0);

      // random programs
      for (int p = 0; p < 12; p++) begin
         gen_prog();
         run_prog(1'b1);
      end

      // T4: reset during EXEC of an ALU instruction
      clear_rom();
      rom[0] = 16'h0B00;
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("t4.busy_exec", busy, 1);
      #2 rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk_all_zero($sformatf("t4.rst%0d", i));
         @(posedge clk); #1;
      end
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_all_zero($sformatf("t4.idle%0d", i));
         @(posedge clk); #1;
      end
      rom[0] = 16'h6000; rom[1] = 16'h6500; rom[2] = 16'h6A00; rom[3] = 16'h6F00;
      rom[4] = 16'h7000;
      run_prog(1'b1);
      chk("t4.r0", o_a[2], 8'h00);  chk("t4.r1", o_a[6], 8'h00);
      chk("t4.r2", o_a[10], 8'h00); chk("t4.r3", o_a[14], 8'h00);

      // T5: register file survives HALT/restart
      clear_rom();
      rom[0] = 16'h187A;
      run_prog(1'b1);
      rom[0] = 16'h6800; rom[1] = 16'h7000;
      run_prog(1'b1);
      chk("t5.refetch_addr", o_addr[0], 8'h00);
      chk("t5.r2_kept", o_a[2], 8'h7A);

      // T6: rd == rs
      clear_rom();
      rom[0] = 16'h1011; rom[1] = 16'h1422; rom[2] = 16'h1833; rom[3] = 16'h1C81;
      rom[4] = 16'h0F00; rom[5] = 16'h6000; rom[6] = 16'h6500; rom[7] = 16'h6A00;
      rom[8] = 16'h6F00;
      run_prog(1'b1);
      chk("t6.a", o_a[18], 8'h81); chk("t6.b", o_b[18], 8'h81);
      chk("t6.wbd", o_wbd[19], 8'h02);
      chk("t6.r0", o_a[22], 8'h11); chk("t6.r1", o_a[26], 8'h22);
      chk("t6.r2", o_a[30], 8'h33); chk("t6.r3", o_a[34], 8'h02);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
